// File: rtl/blink_pkg.sv
// Shared definitions for the blinker remote-control path.
// Command bytes, receiver states and the speed select width.
package blink_pkg;

  localparam int SPEED_W = 3;

  localparam logic [7:0] CMD_RUN     = 8'h52;
  localparam logic [7:0] CMD_PAUSE   = 8'h50;
  localparam logic [7:0] CMD_TOGGLE  = 8'h54;
  localparam logic [7:0] CMD_FASTER  = 8'h2B;
  localparam logic [7:0] CMD_SLOWER  = 8'h2D;
  localparam logic [7:0] CMD_DIGIT0  = 8'h30;
  localparam logic [7:0] CMD_DEFAULT = 8'h21;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with input synchronizer and break handling.
// done/data_q expose the accepted byte one clk early for decoding.
module uart_rx
  import blink_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       done,
  output logic [7:0] data_q
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e state;
  logic [1:0] sync;
  logic [CW-1:0] baud;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic rxs;
  logic bit_end;

  assign rxs     = sync[1];
  assign bit_end = (baud == BIT_LAST);
  assign done    = (state == STOP) && bit_end && rxs;
  assign data_q  = shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      state     <= IDLE;
      baud      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            baud    <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (baud == HALF_LAST) begin
            baud  <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud    <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (rxs) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        // a held-low line reports once, then waits for idle
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_blink_ctrl.sv
// UART command front end for the walking-one blinker.
// Decodes received bytes into run and speed_idx registers.
module uart_blink_ctrl
  import blink_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  output logic               run,
  output logic [SPEED_W-1:0] speed_idx,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               cmd_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  logic done;
  logic [7:0] b;
  logic run_n;
  logic [SPEED_W-1:0] spd_n;
  logic known;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .done     (done),
    .data_q   (b)
  );

  always_comb begin
    run_n = run;
    spd_n = speed_idx;
    known = 1'b1;
    unique case (1'b1)
      (b == CMD_RUN):    run_n = 1'b1;
      (b == CMD_PAUSE):  run_n = 1'b0;
      (b == CMD_TOGGLE): run_n = ~run;
      (b == CMD_FASTER): begin
        if (speed_idx != '1) spd_n = speed_idx + SPEED_W'(1);
      end
      (b == CMD_SLOWER): begin
        if (speed_idx != '0) spd_n = speed_idx - SPEED_W'(1);
      end
      (b[7:3] == CMD_DIGIT0[7:3]): spd_n = b[SPEED_W-1:0];
      (b == CMD_DEFAULT): begin
        run_n = 1'b1;
        spd_n = '0;
      end
      default: known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run       <= 1'b1;
      speed_idx <= '0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (done) begin
        run       <= run_n;
        speed_idx <= spd_n;
        cmd_err   <= ~known;
      end
    end
  end

endmodule

// File: tb/tb_uart_blink_ctrl.sv
// Scoreboard bench for uart_blink_ctrl at 16 clks per bit.
// Stimulus queues expected events; a monitor checks each pulse.
module tb_uart_blink_ctrl;
  import blink_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic run;
  logic [2:0] speed_idx;
  logic [7:0] rx_data;
  logic rx_valid;
  logic frame_err;
  logic cmd_err;

  typedef struct {
    bit         frame;
    logic [7:0] data;
    logic       run;
    logic [2:0] spd;
    logic       cerr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic prev_v = 1'b0;
  logic prev_f = 1'b0;
  logic prev_c = 1'b0;

  always #5 clk = ~clk;

  uart_blink_ctrl #(
    .CLK_FREQ(1_600_000),
    .BAUD    (100_000)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .run      (run),
    .speed_idx(speed_idx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .cmd_err  (cmd_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: pops one expectation per rx_valid or frame_err pulse
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid || frame_err) begin
      chk("excl", {31'b0, rx_valid & frame_err}, 0);
      chk("width", {31'b0, (rx_valid & prev_v) | (frame_err & prev_f)}, 0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'b0, rx_valid, frame_err}, 0);
      end else begin
        e = q.pop_front();
        chk("kind", {31'b0, frame_err}, {31'b0, e.frame});
        chk("rx_data", {24'b0, rx_data}, {24'b0, e.data});
        chk("run", {31'b0, run}, {31'b0, e.run});
        chk("speed_idx", {29'b0, speed_idx}, {29'b0, e.spd});
        chk("cmd_err", {31'b0, cmd_err}, {31'b0, e.cerr});
      end
    end else if (cmd_err) begin
      chk("cmd_err_alone", {31'b0, cmd_err}, 0);
    end
    if (cmd_err && prev_c) chk("cmd_err_width", 1, 0);
    prev_v = rx_valid;
    prev_f = frame_err;
    prev_c = cmd_err;
  end

  task automatic frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic er,
                      input logic [2:0] es, input logic ec);
    exp_t e;
    e.frame = 1'b0;
    e.data  = d;
    e.run   = er;
    e.spd   = es;
    e.cerr  = ec;
    q.push_back(e);
    frame(d, 1'b1);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_run", {31'b0, run}, 1);
    chk("rst_spd", {29'b0, speed_idx}, 0);
    chk("rst_data", {24'b0, rx_data}, 0);
    chk("rst_pulses", {29'b0, rx_valid, frame_err, cmd_err}, 0);
    chk("rst_state", {29'b0, u_dut.u_rx.state}, {29'b0, IDLE});
    repeat (10) @(negedge clk);

    send(8'h50, 1'b0, 3'd0, 1'b0);
    send(8'h2B, 1'b0, 3'd1, 1'b0);
    send(8'h2B, 1'b0, 3'd2, 1'b0);
    send(8'h2B, 1'b0, 3'd3, 1'b0);
    send(8'h2B, 1'b0, 3'd4, 1'b0);
    send(8'h2B, 1'b0, 3'd5, 1'b0);
    send(8'h2B, 1'b0, 3'd6, 1'b0);
    send(8'h2B, 1'b0, 3'd7, 1'b0);
    send(8'h2B, 1'b0, 3'd7, 1'b0);
    send(8'h2D, 1'b0, 3'd6, 1'b0);
    send(8'h33, 1'b0, 3'd3, 1'b0);
    send(8'h21, 1'b1, 3'd0, 1'b0);
    repeat (10) @(negedge clk);

    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_idle", {29'b0, u_dut.u_rx.state}, {29'b0, IDLE});
    send(8'h54, 1'b0, 3'd0, 1'b0);
    repeat (5) @(negedge clk);

    e.frame = 1'b1;
    e.data  = 8'h54;
    e.run   = 1'b0;
    e.spd   = 3'd0;
    e.cerr  = 1'b0;
    q.push_back(e);
    frame(8'h55, 1'b0);
    repeat (40 - CPB) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("break_idle", {29'b0, u_dut.u_rx.state}, {29'b0, IDLE});
    send(8'h50, 1'b0, 3'd0, 1'b0);
    send(8'h41, 1'b0, 3'd0, 1'b1);
    repeat (10) @(negedge clk);

    // abort '7' (0x37) during data bit 4 with a reset
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_run", {31'b0, run}, 1);
    chk("abort_spd", {29'b0, speed_idx}, 0);
    chk("abort_data", {24'b0, rx_data}, 0);
    chk("abort_state", {29'b0, u_dut.u_rx.state}, {29'b0, IDLE});
    send(8'h37, 1'b1, 3'd7, 1'b0);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_blink_ctrl.md
Name: uart_blink_ctrl

Overview:
- Remote-control front end for the LED walking-one blinker.
- Receives 8N1 UART bytes on a single serial pin and decodes single-byte commands into two registered control outputs:
  - `run`: freezes or advances the pattern.
  - `speed_idx`: the downstream blinker divides its half-second step interval by 2^speed_idx.
- Sits directly upstream of the blinker, between the board RX pin and the blinker's control inputs.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD, 115_200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division. Must be >= 8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous, active-low. Clock is clk.
- rx  in  1  asynchronous UART serial input, idle high.
- run  out  1  1 = blinker advances, 0 = blinker holds current LED.
- speed_idx  out  3  step-rate select, 0 = slowest (half-second step).
- rx_data  out  8  last correctly framed byte.
- rx_valid  out  1  one-clk pulse when rx_data updates.
- frame_err  out  1  one-clk pulse when the stop bit is sampled low.
- cmd_err  out  1  one-clk pulse when a valid byte is not a recognised command.

Behaviour:
- Reset values:
  - run=1, speed_idx=0, rx_data=0x00.
  - rx_valid=0, frame_err=0, cmd_err=0.
  - FSM in IDLE, all counters 0.
  - Reset mid-frame abandons the frame and produces no pulse.
- Input conditioning: rx passes through 2-FF synchronizer (both FFs reset to 1). The FSM uses only the synchronized signal rxs.
- FSM states:
  - IDLE: on rxs==0 -> START, bit counter cleared.
  - START: wait CLKS_PER_BIT/2 clks. If rxs still 0 -> DATA. Else -> IDLE (glitch rejected, no pulse).
  - DATA: sample rxs every CLKS_PER_BIT clks, LSB first, 8 samples. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT clks, sample rxs:
    - 1 -> rx_data updated, rx_valid pulse, decode, -> IDLE.
    - 0 -> frame_err pulse, rx_data unchanged, -> BREAK.
  - BREAK: wait for rxs==1, then -> IDLE. A line held low (break) produces exactly one frame_err.
- Latency: rx_valid rises in the clk after the mid-stop-bit sample. This is about 9.5*CLKS_PER_BIT+3 clks after the rx falling edge, bench tolerance ±2.
- Command decode, applied in the same clk as rx_valid:
  - 0x52 'R' -> run=1.
  - 0x50 'P' -> run=0.
  - 0x54 'T' -> run toggles.
  - 0x2B '+' -> speed_idx+1, saturates at 7.
  - 0x2D '-' -> speed_idx-1, saturates at 0.
  - 0x30..0x37 '0'..'7' -> speed_idx = byte[2:0].
  - 0x21 '!' -> run=1, speed_idx=0 (soft default).
  - Any other byte -> no control change, cmd_err pulses in the same clk as rx_valid.
- Back-to-back frames, with a stop bit immediately followed by the next start bit, must be received without loss.
- The IDLE check happens the clk after the STOP exit.
- rx_valid, frame_err and cmd_err are never high longer than one clk.
- frame_err and rx_valid are mutually exclusive.

Decomposition:
- Package blink_pkg holds:
  - Command byte constants: CMD_RUN, CMD_PAUSE, CMD_TOGGLE, CMD_FASTER, CMD_SLOWER, CMD_DIGIT0, CMD_DEFAULT.
  - The RX state enum (IDLE, START, DATA, STOP, BREAK).
  - The 3-bit speed_idx width constant, shared with the blinker.
- Sub-module uart_rx: synchronizer, FSM, bit and baud counters. Outputs rx_data, rx_valid, frame_err.
- Top: command decoder and the run/speed_idx registers.

Test Plan (CLK_FREQ=1_600_000, BAUD=100_000 -> 16 clks/bit):
- Reset, then send 0x50 -> rx_valid pulses once, rx_data=0x50, run 1->0, speed_idx stays 0, cmd_err=0.
- Send '+' eight times back-to-back -> speed_idx goes 1,2,...,7,7. Then '-' once -> 6. Then '3' -> 3. Then '!' -> speed_idx=0, run=1.
- Drive a 5-clk low glitch on rx -> no rx_valid, no frame_err, FSM returns to IDLE. A following 'T' toggles run 1->0.
- Send 0x55 with stop bit forced 0, holding rx low 40 clks -> exactly one frame_err, rx_data keeps prior value, run/speed unchanged. Then rx high, send 'P' -> received correctly.
- Send 0x41 'A' -> rx_valid and cmd_err pulse in the same clk, run/speed_idx unchanged.
- Assert rst_n low at DATA bit 4 of '7', then release -> no pulses, run=1, speed_idx=0. Next full '7' -> speed_idx=7.
